spmv_mem_arbiter: RTL and testbench

- Shares one memory-controller port among N_PE spmv_pe instances.
- Each PE-side request port (ld/st/addr/d_or_tag with stall backpressure) feeds a per-PE request FIFO.
- A round-robin arbiter issues at most one request per cycle to the memory port and extends each load tag with the PE index.
- Returning load responses are routed back to the originating PE by the upper tag bits.

---
 rtl/spmv_mem_arbiter.sv | 115 +++++++++++
 tb/tb_spmv_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_mem_arbiter.sv
// spmv_mem_arbiter: shares one memory-controller port among N_PE PEs via per-PE request FIFOs
// and a round-robin arbiter, and routes load responses back to the PE by tag.
module spmv_mem_arbiter #(
  parameter int N_PE         = 4,
  parameter int ID_W         = 2,
  parameter int TAG_W        = 3,
  parameter int ADDR_W       = 48,
  parameter int FIFO_DEPTH   = 8,
  parameter int STALL_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_PE-1:0]        pe_req_ld,
  input  logic [N_PE-1:0]        pe_req_st,
  input  logic [N_PE*ADDR_W-1:0] pe_req_addr,
  input  logic [N_PE*64-1:0]     pe_req_d_or_tag,
  output logic [N_PE-1:0]        pe_req_stall,
  output logic [N_PE-1:0]        pe_rsp_push,
  output logic [TAG_W-1:0]       pe_rsp_tag,
  output logic [63:0]            pe_rsp_q,
  input  logic [N_PE-1:0]        pe_rsp_stall,
  output logic                   mc_req_ld,
  output logic                   mc_req_st,
  output logic [ADDR_W-1:0]      mc_req_addr,
  output logic [63:0]            mc_req_d_or_tag,
  input  logic                   mc_req_stall,
  input  logic                   mc_rsp_push,
  input  logic [ID_W+TAG_W-1:0]  mc_rsp_tag,
  input  logic [63:0]            mc_rsp_q,
  output logic                   mc_rsp_stall,
  output logic                   err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_W + 64;
  logic [EW-1:0] mem [N_PE][FIFO_DEPTH];
  logic [PW-1:0] wp [N_PE];
  logic [PW-1:0] rp [N_PE];
  logic [CW-1:0] cnt [N_PE];
  logic [N_PE-1:0] push, push_ok, pop;
  logic [ID_W-1:0] last_grant, gid, rsp_id;
  logic gnt, found, rsp_ok, req_err;
  logic g_valid;
  logic [EW-1:0] g_entry;
  logic [ID_W-1:0] g_id;
  always_comb begin
    logic [ID_W-1:0] j;
    j = '0;
    gid = '0;
    found = 1'b0;
    for (int k = 1; k <= N_PE; k++) begin
      j = ID_W'((int'(last_grant) + k) % N_PE);
      if (!found && cnt[j] != '0) begin
        found = 1'b1;
        gid = j;
      end
    end
    gnt = found && !mc_req_stall;
    for (int i = 0; i < N_PE; i++) begin
      push[i] = pe_req_ld[i] | pe_req_st[i];
      push_ok[i] = push[i] && cnt[i] != CW'(FIFO_DEPTH);
      pop[i] = gnt && gid == ID_W'(i);
      pe_req_stall[i] = cnt[i] >= CW'(FIFO_DEPTH - STALL_MARGIN);
    end
    req_err = |(push & ~push_ok) | |(pe_req_ld & pe_req_st);
    rsp_id = mc_rsp_tag[ID_W+TAG_W-1:TAG_W];
    rsp_ok = int'(rsp_id) < N_PE;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PE; i++)
      if (push_ok[i]) mem[i][wp[i]] <= {pe_req_st[i], pe_req_addr[i*ADDR_W +: ADDR_W], pe_req_d_or_tag[i*64 +: 64]};
  end
  // Two stages: grant/pop register, then issue register presented to the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PE; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
      end
      last_grant <= ID_W'(N_PE - 1);
      g_valid <= 1'b0;
      g_entry <= '0;
      g_id <= '0;
      mc_req_ld <= 1'b0;
      mc_req_st <= 1'b0;
      mc_req_addr <= '0;
      mc_req_d_or_tag <= '0;
      pe_rsp_push <= '0;
      pe_rsp_tag <= '0;
      pe_rsp_q <= '0;
      mc_rsp_stall <= 1'b0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < N_PE; i++) begin
        wp[i] <= wp[i] + PW'(push_ok[i]);
        rp[i] <= rp[i] + PW'(pop[i]);
        cnt[i] <= cnt[i] + CW'(push_ok[i]) - CW'(pop[i]);
      end
      if (gnt) last_grant <= gid;
      g_valid <= gnt;
      g_entry <= mem[gid][rp[gid]];
      g_id <= gid;
      mc_req_ld <= g_valid & ~g_entry[EW-1];
      mc_req_st <= g_valid & g_entry[EW-1];
      mc_req_addr <= g_entry[64 +: ADDR_W];
      mc_req_d_or_tag <= g_entry[EW-1] ? g_entry[63:0] : 64'({g_id, g_entry[TAG_W-1:0]});
      pe_rsp_push <= (mc_rsp_push && rsp_ok) ? N_PE'(1) << rsp_id : '0;
      pe_rsp_tag <= mc_rsp_tag[TAG_W-1:0];
      pe_rsp_q <= mc_rsp_q;
      mc_rsp_stall <= |pe_rsp_stall;
      err <= err | req_err | (mc_rsp_push & ~rsp_ok);
    end
  end
endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// tb_spmv_mem_arbiter: directed self-checking bench for spmv_mem_arbiter (4-PE main instance,
// 3-PE instance for out-of-range response ids).
module tb_spmv_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] pe_req_ld = '0, pe_req_st = '0, pe_req_stall, pe_rsp_push, pe_rsp_stall = '0;
  logic [4*48-1:0] pe_req_addr = '0;
  logic [4*64-1:0] pe_req_d_or_tag = '0;
  logic [2:0] pe_rsp_tag;
  logic [63:0] pe_rsp_q, mc_req_d_or_tag, mc_rsp_q = '0;
  logic mc_req_ld, mc_req_st, mc_req_stall = 1'b0, mc_rsp_push = 1'b0, mc_rsp_stall, err;
  logic [47:0] mc_req_addr;
  logic [4:0] mc_rsp_tag = '0;
  logic [2:0] pe_req_stall3, pe_rsp_push3;
  logic [2:0] pe_rsp_tag3;
  logic [63:0] pe_rsp_q3, mc_req_d_or_tag3;
  logic mc_req_ld3, mc_req_st3, mc_rsp_stall3, err3;
  logic [47:0] mc_req_addr3;
  logic mc_rsp_push3 = 1'b0;
  logic [4:0] mc_rsp_tag3 = '0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spmv_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pe_req_ld(pe_req_ld), .pe_req_st(pe_req_st),
    .pe_req_addr(pe_req_addr), .pe_req_d_or_tag(pe_req_d_or_tag), .pe_req_stall(pe_req_stall),
    .pe_rsp_push(pe_rsp_push), .pe_rsp_tag(pe_rsp_tag), .pe_rsp_q(pe_rsp_q),
    .pe_rsp_stall(pe_rsp_stall), .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st),
    .mc_req_addr(mc_req_addr), .mc_req_d_or_tag(mc_req_d_or_tag), .mc_req_stall(mc_req_stall),
    .mc_rsp_push(mc_rsp_push), .mc_rsp_tag(mc_rsp_tag), .mc_rsp_q(mc_rsp_q),
    .mc_rsp_stall(mc_rsp_stall), .err(err));

  spmv_mem_arbiter #(.N_PE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .pe_req_ld(3'b000), .pe_req_st(3'b000),
    .pe_req_addr({3*48{1'b0}}), .pe_req_d_or_tag({3*64{1'b0}}), .pe_req_stall(pe_req_stall3),
    .pe_rsp_push(pe_rsp_push3), .pe_rsp_tag(pe_rsp_tag3), .pe_rsp_q(pe_rsp_q3),
    .pe_rsp_stall(3'b000), .mc_req_ld(mc_req_ld3), .mc_req_st(mc_req_st3),
    .mc_req_addr(mc_req_addr3), .mc_req_d_or_tag(mc_req_d_or_tag3), .mc_req_stall(1'b0),
    .mc_rsp_push(mc_rsp_push3), .mc_rsp_tag(mc_rsp_tag3), .mc_rsp_q(64'h5),
    .mc_rsp_stall(mc_rsp_stall3), .err(err3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({mc_req_ld, mc_req_st, mc_req_addr, mc_req_d_or_tag, pe_req_stall, pe_rsp_push, pe_rsp_tag, pe_rsp_q, mc_rsp_stall, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ld=%b st=%b addr=%h d=%h stall=%b rsp=%b err=%b, want all 0",
               mc_req_ld, mc_req_st, mc_req_addr, mc_req_d_or_tag, pe_req_stall, pe_rsp_push, err);
    end
  endtask

  task automatic test_first_loads();
    logic [63:0] exp_d [4] = '{64'h01, 64'h0A, 64'h13, 64'h1C};
    pe_req_ld = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      pe_req_addr[i*48 +: 48] = 48'((i + 1) * 'h100);
      pe_req_d_or_tag[i*64 +: 64] = 64'(i + 1);
    end
    tick();
    pe_req_ld = '0;
    tick();
    n_chk++;
    if (mc_req_ld !== 1'b0) begin n_fail++; $display("FAIL load_latency: ld=%b want 0", mc_req_ld); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if ({mc_req_ld, mc_req_st, mc_req_d_or_tag, mc_req_addr} !== {2'b10, exp_d[i], 48'((i + 1) * 'h100)}) begin
        n_fail++;
        $display("FAIL load_pe%0d: ld=%b st=%b d=%h addr=%h want ld=1 st=0 d=%h addr=%h",
                 i, mc_req_ld, mc_req_st, mc_req_d_or_tag, mc_req_addr, exp_d[i], (i + 1) * 'h100);
      end
    end
    tick();
    n_chk++;
    if (mc_req_ld !== 1'b0) begin n_fail++; $display("FAIL load_done: ld=%b want 0", mc_req_ld); end
  endtask

  task automatic test_store_alternate();
    logic [63:0] exp_d [4] = '{64'hAAAA_AAAA_AAAA_AAA0, 64'hBBBB_BBBB_BBBB_BBB0,
                               64'hAAAA_AAAA_AAAA_AAA1, 64'hBBBB_BBBB_BBBB_BBB1};
    int n = 0;
    logic exp_st;
    mc_req_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pe_req_st = 4'b0011;
      pe_req_d_or_tag[0 +: 64] = exp_d[2*k];
      pe_req_d_or_tag[64 +: 64] = exp_d[2*k+1];
      tick();
    end
    pe_req_st = '0;
    for (int e = 1; e <= 10; e++) begin
      mc_req_stall = (e % 2 == 1);
      tick();
      exp_st = (e == 3 || e == 5 || e == 7 || e == 9);
      n_chk++;
      if ({mc_req_ld, mc_req_st} !== {1'b0, exp_st}) begin
        n_fail++;
        $display("FAIL store_issue_e%0d: ld=%b st=%b want ld=0 st=%b", e, mc_req_ld, mc_req_st, exp_st);
      end
      if (exp_st) begin
        n_chk++;
        if (mc_req_d_or_tag !== exp_d[n]) begin
          n_fail++;
          $display("FAIL store_data_e%0d: d=%h want %h", e, mc_req_d_or_tag, exp_d[n]);
        end
        n++;
      end
    end
  endtask

  task automatic test_response();
    mc_rsp_push = 1'b1;
    mc_rsp_tag = 5'h0D;
    mc_rsp_q = 64'h3FF0_0000_0000_0000;
    tick();
    mc_rsp_push = 1'b0;
    n_chk++;
    if ({pe_rsp_push, pe_rsp_tag, pe_rsp_q} !== {4'b0010, 3'd5, 64'h3FF0_0000_0000_0000}) begin
      n_fail++;
      $display("FAIL rsp_route: push=%b tag=%0d q=%h want 0010 5 3ff0000000000000", pe_rsp_push, pe_rsp_tag, pe_rsp_q);
    end
    tick();
    n_chk++;
    if (pe_rsp_push !== 4'b0000) begin n_fail++; $display("FAIL rsp_one_cycle: push=%b want 0000", pe_rsp_push); end
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL rsp_err_clean: err=%b want 0", err); end
  endtask

  task automatic test_bad_id();
    mc_rsp_push3 = 1'b1;
    mc_rsp_tag3 = 5'h09;
    tick();
    n_chk++;
    if ({pe_rsp_push3, err3} !== {3'b010, 1'b0}) begin
      n_fail++;
      $display("FAIL n3_valid_id: push=%b err=%b want 010 0", pe_rsp_push3, err3);
    end
    mc_rsp_tag3 = 5'h1D;
    tick();
    mc_rsp_push3 = 1'b0;
    n_chk++;
    if ({pe_rsp_push3, err3} !== {3'b000, 1'b1}) begin
      n_fail++;
      $display("FAIL n3_bad_id: push=%b err=%b want 000 1", pe_rsp_push3, err3);
    end
  endtask

  task automatic test_rsp_stall();
    pe_rsp_stall = 4'b1000;
    #1;
    n_chk++;
    if (mc_rsp_stall !== 1'b0) begin n_fail++; $display("FAIL rsp_stall_delay: got %b want 0", mc_rsp_stall); end
    tick();
    n_chk++;
    if (mc_rsp_stall !== 1'b1) begin n_fail++; $display("FAIL rsp_stall_set: got %b want 1", mc_rsp_stall); end
    pe_rsp_stall = '0;
    tick();
    n_chk++;
    if (mc_rsp_stall !== 1'b0) begin n_fail++; $display("FAIL rsp_stall_clear: got %b want 0", mc_rsp_stall); end
  endtask

  task automatic test_fill();
    mc_req_stall = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      pe_req_ld = 4'b0100;
      pe_req_d_or_tag[128 +: 64] = 64'(k % 8);
      tick();
      pe_req_ld = '0;
      n_chk++;
      if (pe_req_stall[2] !== (k >= 5)) begin
        n_fail++;
        $display("FAIL fill_stall_%0d: stall=%b want %b", k, pe_req_stall[2], k >= 5);
      end
      n_chk++;
      if (err !== (k == 8)) begin
        n_fail++;
        $display("FAIL fill_err_%0d: err=%b want %b", k, err, k == 8);
      end
    end
    n_chk++;
    if (mc_req_ld !== 1'b0) begin n_fail++; $display("FAIL fill_no_issue: ld=%b want 0", mc_req_ld); end
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k < 3; k++) begin
      pe_req_ld = 4'b0010;
      tick();
    end
    pe_req_ld = '0;
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({err, pe_req_stall, mc_req_ld, mc_req_st} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: err=%b stall=%b ld=%b st=%b want 0", err, pe_req_stall, mc_req_ld, mc_req_st);
    end
    tick();
    rst_n = 1'b1;
    mc_req_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if ({mc_req_ld, mc_req_st, pe_req_stall} !== '0) begin
        n_fail++;
        $display("FAIL post_reset_idle_%0d: ld=%b st=%b stall=%b want 0", k, mc_req_ld, mc_req_st, pe_req_stall);
      end
    end
    pe_req_ld = 4'b0010;
    pe_req_addr[48 +: 48] = 48'h500;
    pe_req_d_or_tag[64 +: 64] = 64'd7;
    tick();
    pe_req_ld = '0;
    n_chk++;
    if (mc_req_ld !== 1'b0) begin n_fail++; $display("FAIL post_reset_lat1: ld=%b want 0", mc_req_ld); end
    tick();
    n_chk++;
    if (mc_req_ld !== 1'b0) begin n_fail++; $display("FAIL post_reset_lat2: ld=%b want 0", mc_req_ld); end
    tick();
    n_chk++;
    if ({mc_req_ld, mc_req_d_or_tag, mc_req_addr} !== {1'b1, 64'h0F, 48'h500}) begin
      n_fail++;
      $display("FAIL post_reset_issue: ld=%b d=%h addr=%h want 1 0f 500", mc_req_ld, mc_req_d_or_tag, mc_req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_first_loads();
    test_store_alternate();
    test_response();
    test_rsp_stall();
    test_bad_id();
    test_fill();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
